// File: rtl/entropy_scheduler_pkg.sv
// Shared types for the entropy decoder sequencing controller: bus width,
// component identifiers and scheduler FSM states.
package entropy_scheduler_pkg;

    localparam int IN_BUS_WIDTH = 32;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_id_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with registered read: rd_data updates only on a pop
// and holds its value otherwise.
module word_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 32,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             push_ok, pop_ok;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/entropy_scheduler.sv
// Feeds buffered compressed words to the entropy decoder on request and walks
// the 4:2:0 MCU block order to select the Huffman table bank.
module entropy_scheduler
    import entropy_scheduler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int Y_BLOCKS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             num_mcus,
    input  logic [IN_BUS_WIDTH-1:0] up_data,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic                    dec_request,
    input  logic                    dec_block_valid,
    output logic [IN_BUS_WIDTH-1:0] dec_data,
    output logic                    dec_valid,
    output logic                    tab_sel,
    output logic [1:0]              out_comp,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    sched_state_t state;
    logic         pending;
    logic [2:0]   blk_idx;
    logic [15:0]  mcu_cnt;
    logic [15:0]  num_lat;
    logic         full, empty;
    logic [AW:0]  count;
    logic         pop;
    logic         last_blk, last_mcu;
    comp_id_t     comp;

    // The FIFO's registered read port doubles as the dec_data register.
    word_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(IN_BUS_WIDTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (up_valid),
        .wr_data (up_data),
        .pop     (pop),
        .rd_data (dec_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign up_ready = !full;
    assign pop      = (state == RUN) && pending && !empty;
    assign last_blk = (blk_idx == 3'(Y_BLOCKS + 1));
    assign last_mcu = (mcu_cnt == num_lat - 16'd1);
    assign busy     = (state == RUN);

    always_comb begin
        comp = COMP_CR;
        if (blk_idx < 3'(Y_BLOCKS))       comp = COMP_Y;
        else if (blk_idx == 3'(Y_BLOCKS)) comp = COMP_CB;
    end

    assign out_comp = comp;
    assign tab_sel  = (comp != COMP_Y);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            blk_idx   <= '0;
            mcu_cnt   <= '0;
            num_lat   <= '0;
            dec_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            dec_valid <= pop;
            done      <= 1'b0;
            // A request while a word is still owed is absorbed.
            if (pop)                               pending <= 1'b0;
            else if (state == RUN && dec_request)  pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_mcus != 16'd0) begin
                            state   <= RUN;
                            num_lat <= num_mcus;
                            pending <= 1'b1;
                            blk_idx <= '0;
                            mcu_cnt <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (dec_block_valid) begin
                        if (last_blk) begin
                            blk_idx <= '0;
                            if (last_mcu) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                pending <= 1'b0;
                                mcu_cnt <= '0;
                            end else begin
                                mcu_cnt <= mcu_cnt + 16'd1;
                            end
                        end else begin
                            blk_idx <= blk_idx + 3'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
